// File: rtl/stack_seq.sv
// stack_seq: control sequencer for CALL / RET / RETI and interrupt entry.
// It drives the stack-memory strobes and PC-slice selects one word at a time,
// so that a PC wider than the stack word can be saved and restored.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting; accepts irq (pending or live), RETI, RET, CALL
// DRAIN      | interrupt entry: flush the pipeline with bubbles
// PUSH_PC    | push PC words, upper word first
// PUSH_FLAGS | interrupt entry: push the flags word
// VECTOR     | interrupt entry: load the vector and acknowledge
// CALL_JMP   | CALL: jump to the call target
// POP_FLAGS  | RETI: restore the flags from the stack
// POP_PC     | pop PC words, lower word first
// SETTLE     | let the restored PC settle, then commit the redirect
module stack_seq #(
  parameter int PC_W          = 32,
  parameter int WORD_W        = 16,
  parameter int DRAIN_CYCLES  = 5,
  parameter int SETTLE_CYCLES = 2,
  localparam int PC_WORDS     = PC_W / WORD_W,
  localparam int IDX_W        = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instruction,
  input  logic             instr_valid,
  input  logic             irq,
  output logic             stall_fetch,
  output logic             clear_instruction,
  output logic             mem_push,
  output logic             mem_pop,
  output logic             mem_write,
  output logic             mem_read,
  output logic [1:0]       mem_src_sel,
  output logic [IDX_W-1:0] pc_word_idx,
  output logic             pc_word_load,
  output logic             flag_restore,
  output logic             jump_uncond,
  output logic             pc_load_vector,
  output logic             pc_commit,
  output logic             irq_ack,
  output logic             busy
);

  // Illegal parameter combinations stop elaboration.
  if ((PC_W % WORD_W) != 0) begin : g_bad_pc_w
    $error("stack_seq: PC_W must be a multiple of WORD_W");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("stack_seq: DRAIN_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("stack_seq: SETTLE_CYCLES must be at least 1");
  end

  // One down-counter serves every multi-cycle state.
  localparam int CNT_MAX_A = (DRAIN_CYCLES > PC_WORDS) ? DRAIN_CYCLES : PC_WORDS;
  localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORDS_LD  = CNT_W'(PC_WORDS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PC_WORDS - 1);

  localparam logic [4:0] OP_CALL = 5'b11100;
  localparam logic [4:0] OP_RET  = 5'b11101;
  localparam logic [4:0] OP_RETI = 5'b11110;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_PC    = 2'b01;
  localparam logic [1:0] SRC_FLAGS = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_PC,
    PUSH_FLAGS,
    VECTOR,
    CALL_JMP,
    POP_FLAGS,
    POP_PC,
    SETTLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
  logic             seq_irq, seq_irq_nxt;
  logic             irq_pending, irq_pending_nxt;
  logic [4:0]       opcode;
  logic             unused_instr_bits;

  assign opcode            = instruction[15:11];
  assign unused_instr_bits = ^instruction[10:0];
  assign cnt_dec           = (cnt != '0) ? (cnt - CNT_ONE) : cnt;

  // A live irq re-arms the request even on the acknowledge cycle.
  assign irq_pending_nxt = irq | (irq_pending & ~irq_ack);

  // State, shared counter, sequence kind and pending-interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      seq_irq     <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      seq_irq     <= seq_irq_nxt;
      irq_pending <= irq_pending_nxt;
    end
  end

  // Next-state, counter reload and per-state output decode.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt_dec;
    seq_irq_nxt       = seq_irq;
    stall_fetch       = 1'b0;
    clear_instruction = 1'b0;
    mem_push          = 1'b0;
    mem_pop           = 1'b0;
    mem_write         = 1'b0;
    mem_read          = 1'b0;
    mem_src_sel       = SRC_NONE;
    pc_word_idx       = '0;
    pc_word_load      = 1'b0;
    flag_restore      = 1'b0;
    jump_uncond       = 1'b0;
    pc_load_vector    = 1'b0;
    pc_commit         = 1'b0;
    irq_ack           = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (irq_pending || irq) begin
          stall_fetch = 1'b1;
          state_nxt   = DRAIN;
          cnt_nxt     = DRAIN_LD;
          seq_irq_nxt = 1'b1;
        end else if (instr_valid && opcode == OP_RETI) begin
          stall_fetch = 1'b1;
          state_nxt   = POP_FLAGS;
          seq_irq_nxt = 1'b0;
        end else if (instr_valid && opcode == OP_RET) begin
          stall_fetch = 1'b1;
          state_nxt   = POP_PC;
          cnt_nxt     = WORDS_LD;
          seq_irq_nxt = 1'b0;
        end else if (instr_valid && opcode == OP_CALL) begin
          stall_fetch = 1'b1;
          state_nxt   = PUSH_PC;
          cnt_nxt     = WORDS_LD;
          seq_irq_nxt = 1'b0;
        end
      end

      DRAIN: begin
        stall_fetch       = 1'b1;
        clear_instruction = 1'b1;
        if (cnt == '0) begin
          state_nxt = PUSH_PC;
          cnt_nxt   = WORDS_LD;
        end
      end

      // The counter doubles as the word index: upper word leaves first.
      PUSH_PC: begin
        stall_fetch = 1'b1;
        mem_push    = 1'b1;
        mem_write   = 1'b1;
        mem_src_sel = SRC_PC;
        pc_word_idx = IDX_W'(cnt);
        if (cnt == '0) begin
          state_nxt = seq_irq ? PUSH_FLAGS : CALL_JMP;
          cnt_nxt   = '0;
        end
      end

      PUSH_FLAGS: begin
        stall_fetch = 1'b1;
        mem_push    = 1'b1;
        mem_write   = 1'b1;
        mem_src_sel = SRC_FLAGS;
        state_nxt   = VECTOR;
        cnt_nxt     = '0;
      end

      VECTOR: begin
        stall_fetch    = 1'b1;
        pc_load_vector = 1'b1;
        irq_ack        = 1'b1;
        state_nxt      = IDLE;
        cnt_nxt        = '0;
      end

      CALL_JMP: begin
        stall_fetch = 1'b1;
        jump_uncond = 1'b1;
        state_nxt   = IDLE;
        cnt_nxt     = '0;
      end

      POP_FLAGS: begin
        stall_fetch       = 1'b1;
        clear_instruction = 1'b1;
        mem_pop           = 1'b1;
        mem_read          = 1'b1;
        flag_restore      = 1'b1;
        state_nxt         = POP_PC;
        cnt_nxt           = WORDS_LD;
      end

      // Pops return in reverse push order, so the index counts upward.
      POP_PC: begin
        stall_fetch       = 1'b1;
        clear_instruction = 1'b1;
        mem_pop           = 1'b1;
        mem_read          = 1'b1;
        pc_word_load      = 1'b1;
        pc_word_idx       = LAST_IDX - IDX_W'(cnt);
        if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LD;
        end
      end

      SETTLE: begin
        stall_fetch       = 1'b1;
        clear_instruction = 1'b1;
        if (cnt == '0) begin
          pc_commit = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
